pe_if: RTL and testbench
========================

PE_IF -- requirements
Module: pe_if

Interface
REQ-001 Parameter PC_WIDTH, default 13, instruction-memory word-address width.
REQ-002 Parameter INS_WIDTH, default 29, fetched word width (instruction + data-select + predication bits).
REQ-003 Port iClk, input, 1, system clock, positive-edge trigger.
REQ-004 Port iReset, input, 1, asynchronous active-high reset; one clock, asynchronous active-high reset.
REQ-005 Port iStart, input, 1, start-fetch pulse.
REQ-006 Port iStart_PC, input, PC_WIDTH, first fetch address.
REQ-007 Port iHalt, input, 1, stop-fetch request.
REQ-008 Port iStall, input, 1, downstream cannot accept current instruction.
REQ-009 Port iBranch_Valid, input, 1, redirect fetch.
REQ-010 Port iBranch_Target, input, PC_WIDTH, redirect address.
REQ-011 Port oIF_IMEM_Addr, output, PC_WIDTH, address to instruction memory (1-cycle synchronous read).
REQ-012 Port iIMEM_IF_Instruction, input, INS_WIDTH, word returned by instruction memory.
REQ-013 Port oIF_Instruction, output, INS_WIDTH, fetched instruction to decode.
REQ-014 Port oIF_PC, output, PC_WIDTH, address of oIF_Instruction.
REQ-015 Port oIF_Valid, output, 1, oIF_Instruction/oIF_PC are a real fetch.
REQ-016 Port oRunning, output, 1, FSM in RUN.
REQ-017 Port oFetch_Count, output, 32, instructions accepted since reset.

Function
REQ-018 FSM states IDLE, RUN; IDLE->RUN on iStart; RUN->IDLE on iHalt; iStart in RUN ignored; iHalt in IDLE ignored.
REQ-019 oIF_IMEM_Addr combinational, priority: iStart in IDLE -> iStart_PC; RUN & iBranch_Valid -> iBranch_Target; RUN & iStall -> rOut_PC (re-read held word); else rPC.
REQ-020 Registered rPC <= (presented address + 1) mod 2^PC_WIDTH whenever state is/enters RUN and not (iStall without branch); wrap 2^PC_WIDTH-1 -> 0 with no special action.
REQ-021 oIF_PC registered: follows the address presented in the previous cycle; memory latency 1 cycle, so oIF_Instruction = iIMEM_IF_Instruction pass-through, aligned to oIF_PC.
REQ-022 oIF_Valid <= 1 in the cycle after any address presented in RUN or on start; <= 0 in cycle after a halt or while IDLE.
REQ-023 Stall: rPC, oIF_PC, oIF_Valid held; re-read of rOut_PC keeps oIF_Instruction stable for any stall length.
REQ-024 Branch: zero bubble, target word valid the next cycle; branch overrides simultaneous iStall.
REQ-025 iHalt with iBranch_Valid same cycle: halt wins, no redirect; rPC unchanged.
REQ-026 oRunning = (state == RUN).
REQ-027 oFetch_Count increments by 1 each cycle oIF_Valid=1 and iStall=0, wraps at 2^32.
REQ-028 In IDLE, oIF_IMEM_Addr = rPC, no state changes except start.

Reset
REQ-029 iReset asynchronous: state IDLE, rPC=0, oIF_PC=0, oIF_Valid=0, oFetch_Count=0, oRunning=0; oIF_IMEM_Addr=0.
REQ-030 Reset mid-RUN aborts fetch immediately; no valid output until a new iStart after reset release.

Verification
REQ-031 Reset, iStart with iStart_PC=0x010, no stall -> addr 0x010,0x011,0x012...; oIF_Valid=1 from next cycle with oIF_PC=0x010,0x011...
REQ-032 Running at oIF_PC=0x020, iStall high 3 cycles -> oIF_PC=0x020, instruction stable 4 cycles, then 0x021; oFetch_Count +1 only on the non-stalled cycle.
REQ-033 iBranch_Valid target 0x100 while iStall=1 -> next cycle oIF_PC=0x100 valid, then 0x101.
REQ-034 iStart_PC=0x1FFE (PC_WIDTH=13) -> oIF_PC sequence 0x1FFE,0x1FFF,0x0000.
REQ-035 iHalt and iBranch_Valid same cycle -> oIF_Valid=0 next cycle, oRunning=0, no fetch of target.
REQ-036 iReset asserted mid-RUN -> all outputs zero asynchronously; iStart ignored while reset high.

Source files
------------

// File: rtl/pe_if.sv
// Instruction-fetch stage: drives a 1-cycle synchronous instruction memory and
// presents each fetched word with its address, honouring start/halt, stall and branch.
module pe_if #(
  parameter int PC_WIDTH  = 13,
  parameter int INS_WIDTH = 29
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic [PC_WIDTH-1:0]  iStart_PC,
  input  logic                 iHalt,
  input  logic                 iStall,
  input  logic                 iBranch_Valid,
  input  logic [PC_WIDTH-1:0]  iBranch_Target,
  output logic [PC_WIDTH-1:0]  oIF_IMEM_Addr,
  input  logic [INS_WIDTH-1:0] iIMEM_IF_Instruction,
  output logic [INS_WIDTH-1:0] oIF_Instruction,
  output logic [PC_WIDTH-1:0]  oIF_PC,
  output logic                 oIF_Valid,
  output logic                 oRunning,
  output logic [31:0]          oFetch_Count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  r_out_pc;
  logic                 r_valid;
  logic [31:0]          r_fetch_count;

  logic                 w_run;
  logic                 w_start;
  logic                 w_redirect;
  logic                 w_hold;
  logic [PC_WIDTH-1:0]  w_addr;
  logic [PC_WIDTH-1:0]  w_addr_inc;

  // Address selection; a halt suppresses both redirect and stall re-read.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_start    = !w_run && iStart;
    w_redirect = w_run && !iHalt && iBranch_Valid;
    w_hold     = w_run && !iHalt && !iBranch_Valid && iStall;
    if (iReset) begin
      w_addr = '0;
    end else if (w_start) begin
      w_addr = iStart_PC;
    end else if (w_redirect) begin
      w_addr = iBranch_Target;
    end else if (w_hold) begin
      w_addr = r_out_pc;
    end else begin
      w_addr = r_pc;
    end
    w_addr_inc = w_addr + PC_WIDTH'(1);
  end

  // Fetch FSM with its registered PC, output PC and valid flag.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_out_pc <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_state  <= ST_RUN;
            r_pc     <= w_addr_inc;
            r_out_pc <= w_addr;
            r_valid  <= 1'b1;
          end else begin
            r_valid  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (iHalt) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
          end else if (!w_hold) begin
            r_pc     <= w_addr_inc;
            r_out_pc <= w_addr;
            r_valid  <= 1'b1;
          end else begin
            r_valid  <= r_valid;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Accepted-instruction counter: a valid word is consumed when downstream is not stalled.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_fetch_count <= 32'd0;
    end else if (r_valid && !iStall) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  // Memory read latency equals the output register latency, so data passes straight through.
  assign oIF_IMEM_Addr   = w_addr;
  assign oIF_Instruction = iIMEM_IF_Instruction;
  assign oIF_PC          = r_out_pc;
  assign oIF_Valid       = r_valid;
  assign oRunning        = (r_state == ST_RUN);
  assign oFetch_Count    = r_fetch_count;

endmodule

// File: tb/tb_pe_if.sv
// Self-checking bench for pe_if: directed scenarios plus a randomized run
// compared against a fetch-stream reference model.
module tb_pe_if;

  logic        clk;
  logic        iReset;
  logic        iStart;
  logic [12:0] iStart_PC;
  logic        iHalt;
  logic        iStall;
  logic        iBranch_Valid;
  logic [12:0] iBranch_Target;
  logic [12:0] oIF_IMEM_Addr;
  logic [28:0] imem_q;
  logic [28:0] oIF_Instruction;
  logic [12:0] oIF_PC;
  logic        oIF_Valid;
  logic        oRunning;
  logic [31:0] oFetch_Count;

  int          n_cmp;
  int          n_bad;
  logic [12:0] seen_addr;

  pe_if #(.PC_WIDTH(13), .INS_WIDTH(29)) dut (
    .iClk                 (clk),
    .iReset               (iReset),
    .iStart               (iStart),
    .iStart_PC            (iStart_PC),
    .iHalt                (iHalt),
    .iStall               (iStall),
    .iBranch_Valid        (iBranch_Valid),
    .iBranch_Target       (iBranch_Target),
    .oIF_IMEM_Addr        (oIF_IMEM_Addr),
    .iIMEM_IF_Instruction (imem_q),
    .oIF_Instruction      (oIF_Instruction),
    .oIF_PC               (oIF_PC),
    .oIF_Valid            (oIF_Valid),
    .oRunning             (oRunning),
    .oFetch_Count         (oFetch_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: unique per address, low bits carry the address itself.
  function automatic logic [28:0] mem_word(input logic [12:0] a);
    logic [12:0] h;
    h = (a * 13'd37) ^ 13'h15A3;
    return {h, a[2:0], a};
  endfunction

  // Synchronous one-cycle instruction memory.
  always @(posedge clk) imem_q <= mem_word(oIF_IMEM_Addr);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step(input logic st, input logic [12:0] spc, input logic hl,
                      input logic sl, input logic br, input logic [12:0] tg);
    iStart = st; iStart_PC = spc; iHalt = hl; iStall = sl;
    iBranch_Valid = br; iBranch_Target = tg;
    #1;
    seen_addr = oIF_IMEM_Addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0);
  endtask

  task automatic apply_reset();
    iReset = 1'b1; iStart = 1'b0; iStart_PC = 13'h0; iHalt = 1'b0;
    iStall = 1'b0; iBranch_Valid = 1'b0; iBranch_Target = 13'h0;
    @(negedge clk);
    @(negedge clk);
    iReset = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1; iStart = 1'b1; iStart_PC = 13'h123; iHalt = 1'b0;
    iStall = 1'b0; iBranch_Valid = 1'b0; iBranch_Target = 13'h0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (oIF_IMEM_Addr !== 13'h0) begin n_bad++; $display("FAIL reset_addr: got %0h expected 0", oIF_IMEM_Addr); end
    n_cmp++; if (oIF_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", oIF_Valid); end
    n_cmp++; if (oRunning !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %0b expected 0", oRunning); end
    n_cmp++; if (oIF_PC !== 13'h0) begin n_bad++; $display("FAIL reset_pc: got %0h expected 0", oIF_PC); end
    n_cmp++; if (oFetch_Count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", oFetch_Count); end
    iStart = 1'b0;
    iReset = 1'b0;
    idle_step();
    n_cmp++; if (oRunning !== 1'b0 || oIF_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got run=%0b valid=%0b expected 0 0", oRunning, oIF_Valid); end
  endtask

  task automatic test_sequential();
    apply_reset();
    step(1'b1, 13'h010, 1'b0, 1'b0, 1'b0, 13'h0);
    n_cmp++; if (seen_addr !== 13'h010) begin n_bad++; $display("FAIL seq_start_addr: got %0h expected 10", seen_addr); end
    n_cmp++; if (oIF_PC !== 13'h010 || oIF_Valid !== 1'b1 || oRunning !== 1'b1) begin n_bad++; $display("FAIL seq_start_out: got pc=%0h v=%0b r=%0b expected 10 1 1", oIF_PC, oIF_Valid, oRunning); end
    n_cmp++; if (oIF_Instruction !== mem_word(13'h010)) begin n_bad++; $display("FAIL seq_start_ins: got %0h expected %0h", oIF_Instruction, mem_word(13'h010)); end
    for (int i = 1; i <= 4; i++) begin
      idle_step();
      n_cmp++; if (seen_addr !== 13'h010 + 13'(i)) begin n_bad++; $display("FAIL seq_addr: got %0h expected %0h", seen_addr, 13'h010 + 13'(i)); end
      n_cmp++; if (oIF_PC !== 13'h010 + 13'(i) || oIF_Valid !== 1'b1) begin n_bad++; $display("FAIL seq_pc: got %0h v=%0b expected %0h 1", oIF_PC, oIF_Valid, 13'h010 + 13'(i)); end
      n_cmp++; if (oFetch_Count !== 32'(i)) begin n_bad++; $display("FAIL seq_count: got %0d expected %0d", oFetch_Count, i); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step(1'b1, 13'h01D, 1'b0, 1'b0, 1'b0, 13'h0);
    for (int i = 0; i < 3; i++) idle_step();
    n_cmp++; if (oIF_PC !== 13'h020 || oFetch_Count !== 32'd3) begin n_bad++; $display("FAIL stall_pre: got pc=%0h cnt=%0d expected 20 3", oIF_PC, oFetch_Count); end
    n_cmp++; if (oIF_Instruction !== mem_word(13'h020)) begin n_bad++; $display("FAIL stall_pre_ins: got %0h expected %0h", oIF_Instruction, mem_word(13'h020)); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 13'h0, 1'b0, 1'b1, 1'b0, 13'h0);
      n_cmp++; if (seen_addr !== 13'h020) begin n_bad++; $display("FAIL stall_addr: got %0h expected 20", seen_addr); end
      n_cmp++; if (oIF_PC !== 13'h020 || oIF_Valid !== 1'b1) begin n_bad++; $display("FAIL stall_pc: got %0h v=%0b expected 20 1", oIF_PC, oIF_Valid); end
      n_cmp++; if (oIF_Instruction !== mem_word(13'h020)) begin n_bad++; $display("FAIL stall_ins: got %0h expected %0h", oIF_Instruction, mem_word(13'h020)); end
      n_cmp++; if (oFetch_Count !== 32'd3) begin n_bad++; $display("FAIL stall_count: got %0d expected 3", oFetch_Count); end
    end
    idle_step();
    n_cmp++; if (oIF_PC !== 13'h021 || oFetch_Count !== 32'd4) begin n_bad++; $display("FAIL stall_post: got pc=%0h cnt=%0d expected 21 4", oIF_PC, oFetch_Count); end
  endtask

  task automatic test_branch_stall();
    apply_reset();
    step(1'b1, 13'h040, 1'b0, 1'b0, 1'b0, 13'h0);
    idle_step();
    step(1'b0, 13'h0, 1'b0, 1'b1, 1'b1, 13'h100);
    n_cmp++; if (seen_addr !== 13'h100) begin n_bad++; $display("FAIL br_addr: got %0h expected 100", seen_addr); end
    n_cmp++; if (oIF_PC !== 13'h100 || oIF_Valid !== 1'b1) begin n_bad++; $display("FAIL br_pc: got %0h v=%0b expected 100 1", oIF_PC, oIF_Valid); end
    n_cmp++; if (oIF_Instruction !== mem_word(13'h100)) begin n_bad++; $display("FAIL br_ins: got %0h expected %0h", oIF_Instruction, mem_word(13'h100)); end
    idle_step();
    n_cmp++; if (oIF_PC !== 13'h101 || oFetch_Count !== 32'd2) begin n_bad++; $display("FAIL br_next: got pc=%0h cnt=%0d expected 101 2", oIF_PC, oFetch_Count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(1'b1, 13'h1FFE, 1'b0, 1'b0, 1'b0, 13'h0);
    n_cmp++; if (oIF_PC !== 13'h1FFE) begin n_bad++; $display("FAIL wrap_0: got %0h expected 1ffe", oIF_PC); end
    idle_step();
    n_cmp++; if (oIF_PC !== 13'h1FFF) begin n_bad++; $display("FAIL wrap_1: got %0h expected 1fff", oIF_PC); end
    idle_step();
    n_cmp++; if (oIF_PC !== 13'h0000 || oIF_Valid !== 1'b1) begin n_bad++; $display("FAIL wrap_2: got %0h v=%0b expected 0 1", oIF_PC, oIF_Valid); end
    n_cmp++; if (oIF_Instruction !== mem_word(13'h0000)) begin n_bad++; $display("FAIL wrap_ins: got %0h expected %0h", oIF_Instruction, mem_word(13'h0000)); end
    idle_step();
    n_cmp++; if (oIF_PC !== 13'h0001) begin n_bad++; $display("FAIL wrap_3: got %0h expected 1", oIF_PC); end
  endtask

  task automatic test_halt_branch();
    apply_reset();
    step(1'b1, 13'h050, 1'b0, 1'b0, 1'b0, 13'h0);
    idle_step();
    step(1'b0, 13'h0, 1'b1, 1'b0, 1'b1, 13'h100);
    n_cmp++; if (seen_addr === 13'h100) begin n_bad++; $display("FAIL hb_addr: got %0h expected not 100", seen_addr); end
    n_cmp++; if (oIF_Valid !== 1'b0 || oRunning !== 1'b0) begin n_bad++; $display("FAIL hb_out: got v=%0b r=%0b expected 0 0", oIF_Valid, oRunning); end
    idle_step();
    n_cmp++; if (seen_addr !== 13'h052) begin n_bad++; $display("FAIL hb_idle_addr: got %0h expected 52", seen_addr); end
    n_cmp++; if (oIF_Valid !== 1'b0 || oRunning !== 1'b0) begin n_bad++; $display("FAIL hb_idle: got v=%0b r=%0b expected 0 0", oIF_Valid, oRunning); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1, 13'h060, 1'b0, 1'b0, 1'b0, 13'h0);
    idle_step();
    idle_step();
    #2;
    iReset = 1'b1;
    iStart = 1'b1;
    iStart_PC = 13'h0AA;
    #1;
    n_cmp++; if (oIF_Valid !== 1'b0 || oRunning !== 1'b0 || oIF_PC !== 13'h0) begin n_bad++; $display("FAIL areset_now: got v=%0b r=%0b pc=%0h expected 0 0 0", oIF_Valid, oRunning, oIF_PC); end
    n_cmp++; if (oFetch_Count !== 32'd0 || oIF_IMEM_Addr !== 13'h0) begin n_bad++; $display("FAIL areset_cnt_addr: got cnt=%0d addr=%0h expected 0 0", oFetch_Count, oIF_IMEM_Addr); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (oRunning !== 1'b0 || oIF_Valid !== 1'b0 || oIF_IMEM_Addr !== 13'h0) begin n_bad++; $display("FAIL areset_hold: got r=%0b v=%0b addr=%0h expected 0 0 0", oRunning, oIF_Valid, oIF_IMEM_Addr); end
    iStart = 1'b0;
    iReset = 1'b0;
    idle_step();
    n_cmp++; if (oRunning !== 1'b0 || oIF_Valid !== 1'b0) begin n_bad++; $display("FAIL areset_after: got r=%0b v=%0b expected 0 0", oRunning, oIF_Valid); end
  endtask

  // Reference model: a stream of fetched addresses; each cycle emits a new address,
  // repeats the current one, or emits nothing, according to the control inputs.
  task automatic test_random();
    bit          m_run;
    int          m_next;
    int          m_pc;
    bit          m_valid;
    logic [31:0] m_cnt;
    int          exp_addr;
    logic        st, hl, sl, br;
    logic [12:0] spc, tg;
    apply_reset();
    m_run = 0; m_next = 0; m_pc = 0; m_valid = 0; m_cnt = 32'd0;
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom_range(0, 7) == 0);
      hl  = ($urandom_range(0, 24) == 0);
      sl  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      spc = ($urandom_range(0, 3) == 0) ? 13'(8190 + $urandom_range(0, 1)) : 13'($urandom);
      tg  = 13'($urandom);
      if (!m_run) exp_addr = st ? int'(spc) : m_next;
      else if (hl) exp_addr = m_next;
      else if (br) exp_addr = int'(tg);
      else if (sl) exp_addr = m_pc;
      else exp_addr = m_next;
      step(st, spc, hl, sl, br, tg);
      if (m_valid && !sl) m_cnt = m_cnt + 32'd1;
      if (!m_run) begin
        if (st) begin m_run = 1; m_valid = 1; m_pc = exp_addr; m_next = (exp_addr + 1) % 8192; end
        else m_valid = 0;
      end else if (hl) begin
        m_run = 0; m_valid = 0;
      end else if (br || !sl) begin
        m_valid = 1; m_pc = exp_addr; m_next = (exp_addr + 1) % 8192;
      end
      n_cmp++; if (seen_addr !== 13'(exp_addr)) begin n_bad++; $display("FAIL rnd_addr c=%0d: got %0h expected %0h", c, seen_addr, exp_addr); end
      n_cmp++; if (oRunning !== m_run || oIF_Valid !== m_valid) begin n_bad++; $display("FAIL rnd_ctl c=%0d: got r=%0b v=%0b expected %0b %0b", c, oRunning, oIF_Valid, m_run, m_valid); end
      n_cmp++; if (oFetch_Count !== m_cnt) begin n_bad++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, oFetch_Count, m_cnt); end
      if (m_valid) begin
        n_cmp++; if (oIF_PC !== 13'(m_pc)) begin n_bad++; $display("FAIL rnd_pc c=%0d: got %0h expected %0h", c, oIF_PC, m_pc); end
        n_cmp++; if (oIF_Instruction !== mem_word(13'(m_pc))) begin n_bad++; $display("FAIL rnd_ins c=%0d: got %0h expected %0h", c, oIF_Instruction, mem_word(13'(m_pc))); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    iReset = 1'b1; iStart = 1'b0; iStart_PC = 13'h0; iHalt = 1'b0;
    iStall = 1'b0; iBranch_Valid = 1'b0; iBranch_Target = 13'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_halt_branch();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
